// File: rtl/fifo_srl_param_if.sv
// Handshake and status bundle for fifo_srl_param.
// The producer/consumer side uses the master modport and the FIFO uses the slave modport.
interface fifo_srl_param_if #(
  parameter int DATA_WIDTH = 1,
  parameter int CNT_WIDTH  = 2
);
  logic                  if_empty_n;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_full_n;
  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic [CNT_WIDTH-1:0]  if_num_data_valid;
  logic [CNT_WIDTH-1:0]  if_fifo_cap;
  logic                  if_almost_full;
  logic                  if_almost_empty;
  logic                  if_overflow;
  logic                  if_underflow;

  modport master (
    input  if_empty_n, if_dout, if_full_n, if_num_data_valid, if_fifo_cap,
           if_almost_full, if_almost_empty, if_overflow, if_underflow,
    output if_read_ce, if_read, if_write_ce, if_write, if_din
  );

  modport slave (
    output if_empty_n, if_dout, if_full_n, if_num_data_valid, if_fifo_cap,
           if_almost_full, if_almost_empty, if_overflow, if_underflow,
    input  if_read_ce, if_read, if_write_ce, if_write, if_din
  );
endinterface

// File: rtl/fifo_srl_param.sv
// Shift-register FIFO: writes shift the array and load entry 0.
// The head of the queue sits at entry count-1, with registered empty/full and sticky error flags.
module fifo_srl_param #(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 1,
  parameter int CNT_WIDTH  = 2,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic            clk,
  input  logic            reset,
  fifo_srl_param_if.slave fifo
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [CNT_WIDTH-1:0]  count_m1;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  empty_n_q, empty_n_d;
  logic                  full_n_q, full_n_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_try, rd_try, wr_acc, rd_acc;

  assign wr_try = fifo.if_write & fifo.if_write_ce;
  assign rd_try = fifo.if_read & fifo.if_read_ce;
  assign wr_acc = wr_try & full_n_q;
  assign rd_acc = rd_try & empty_n_q;

  // Storage is deliberately left out of reset; the count alone defines validity.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        mem_q[i] <= mem_q[i-1];
      end
      mem_q[0] <= fifo.if_din;
    end
  end

  assign count_m1 = count_q - CNT_WIDTH'(1);
  assign rd_addr  = (count_q != '0) ? count_m1[ADDR_WIDTH-1:0] : '0;

  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
    empty_n_d = (count_d != '0);
    full_n_d  = (count_d != CNT_WIDTH'(DEPTH));
    // A rejected write counts as overflow only if no read drains the FIFO in the same cycle;
    // likewise, a read on empty is harmless when a write arrives alongside it.
    if (wr_try && !full_n_q && !rd_acc) overflow_d = 1'b1;
    if (rd_try && !empty_n_q && !wr_acc) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      empty_n_q   <= 1'b0;
      full_n_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      empty_n_q   <= empty_n_d;
      full_n_q    <= full_n_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign fifo.if_dout           = mem_q[rd_addr];
  assign fifo.if_empty_n        = empty_n_q;
  assign fifo.if_full_n         = full_n_q;
  assign fifo.if_num_data_valid = count_q;
  assign fifo.if_fifo_cap       = CNT_WIDTH'(DEPTH);
  assign fifo.if_almost_full    = (count_q >= CNT_WIDTH'(AF_LEVEL));
  assign fifo.if_almost_empty   = (count_q <= CNT_WIDTH'(AE_LEVEL));
  assign fifo.if_overflow       = overflow_q;
  assign fifo.if_underflow      = underflow_q;

endmodule

// File: tb/tb_fifo_srl_param.sv
// Randomised and directed bench for fifo_srl_param (8-bit, depth 4) against a queue-based model.
// Stimulus pushes expected read data; a negedge monitor pops and compares.
module tb_fifo_srl_param;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int CW    = 3;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_srl_param_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) fifo ();

  fifo_srl_param #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW),
    .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .fifo  (fifo.slave)
  );

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_q   [$];
  bit  m_ovf, m_unf;
  bit  chk_en = 1'b0;
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; the model is updated just after the edge.
  task automatic drive(input bit w, input bit r, input bit wce, input bit rce, input logic [DW-1:0] d);
    bit wa, ra, ovf_set, unf_set;
    fifo.if_write    = w;
    fifo.if_read     = r;
    fifo.if_write_ce = wce;
    fifo.if_read_ce  = rce;
    fifo.if_din      = d;
    wa = w && wce && (model_q.size() < DEPTH);
    ra = r && rce && (model_q.size() > 0);
    ovf_set = w && wce && (model_q.size() == DEPTH) && !ra;
    unf_set = r && rce && (model_q.size() == 0) && !wa;
    if (ra) exp_q.push_back(model_q[0]);
    @(posedge clk); #1;
    if (ra) void'(model_q.pop_front());
    if (wa) model_q.push_back(d);
    m_ovf = m_ovf | ovf_set;
    m_unf = m_unf | unf_set;
  endtask

  task automatic do_reset(input bit w, input logic [DW-1:0] d);
    reset            = 1'b1;
    fifo.if_write    = w;
    fifo.if_write_ce = w;
    fifo.if_din      = d;
    fifo.if_read     = 1'b0;
    fifo.if_read_ce  = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Monitor: status compared to the model every cycle, read data popped on each accepted read.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count",        32'(fifo.if_num_data_valid), 32'(model_q.size()));
      chk("empty_n",      32'(fifo.if_empty_n),        32'(model_q.size() != 0));
      chk("full_n",       32'(fifo.if_full_n),         32'(model_q.size() != DEPTH));
      chk("almost_full",  32'(fifo.if_almost_full),    32'(model_q.size() >= AF));
      chk("almost_empty", 32'(fifo.if_almost_empty),   32'(model_q.size() <= AE));
      chk("overflow",     32'(fifo.if_overflow),       32'(m_ovf));
      chk("underflow",    32'(fifo.if_underflow),      32'(m_unf));
      chk("fifo_cap",     32'(fifo.if_fifo_cap),       32'(DEPTH));
      if (!reset && fifo.if_read && fifo.if_read_ce && fifo.if_empty_n) begin
        if (exp_q.size() == 0) begin
          chk("read_unexpected", 32'(fifo.if_dout), 32'hFFFF_FFFF);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          $display("read dout=0x%02h expected=0x%02h", fifo.if_dout, e);
          chk("dout", 32'(fifo.if_dout), 32'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    fifo.if_write = 1'b0; fifo.if_read = 1'b0;
    fifo.if_write_ce = 1'b0; fifo.if_read_ce = 1'b0;
    fifo.if_din = '0;
    m_ovf = 1'b0; m_unf = 1'b0;
    @(posedge clk); #1;
    do_reset(1'b0, 8'h00);
    chk_en = 1'b1;
    idle(1);

    // Write four, then drain in order.
    drive(1, 0, 1, 1, 8'h11); drive(1, 0, 1, 1, 8'h22);
    drive(1, 0, 1, 1, 8'h33); drive(1, 0, 1, 1, 8'h44);
    for (int i = 0; i < 4; i++) drive(0, 1, 1, 1, 8'h00);

    // Full: simultaneous read and write drains one, rejects the write, no overflow.
    drive(1, 0, 1, 1, 8'h11); drive(1, 0, 1, 1, 8'h22);
    drive(1, 0, 1, 1, 8'h33); drive(1, 0, 1, 1, 8'h44);
    drive(1, 1, 1, 1, 8'h55);
    drive(0, 1, 1, 1, 8'h00);

    // Count 2: ten cycles of concurrent read/write keep the level steady.
    for (int i = 0; i < 10; i++) drive(1, 1, 1, 1, 8'($urandom));
    drive(0, 1, 1, 1, 8'h00); drive(0, 1, 1, 1, 8'h00);

    // Empty: simultaneous read and write accepts only the write, no underflow.
    drive(1, 1, 1, 1, 8'hA5);
    idle(1);
    drive(0, 1, 1, 1, 8'h00);

    // Sticky overflow and underflow, held until reset.
    for (int i = 0; i < 4; i++) drive(1, 0, 1, 1, 8'(8'h60 + i));
    drive(1, 0, 1, 1, 8'hEE);
    idle(2);
    for (int i = 0; i < 4; i++) drive(0, 1, 1, 1, 8'h00);
    drive(0, 1, 1, 1, 8'h00);
    idle(2);

    // Disabled clock enables must not change anything.
    drive(1, 1, 0, 0, 8'h77);
    drive(1, 0, 0, 1, 8'h78);

    // Mid-operation reset with a write pending discards everything.
    do_reset(1'b0, 8'h00);
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 1, 8'(8'h30 + i));
    do_reset(1'b1, 8'h99);
    drive(1, 0, 1, 1, 8'h66);
    drive(0, 1, 1, 1, 8'h00);

    // Random traffic with periodic resets.
    for (int i = 0; i < 400; i++) begin
      if (i % 60 == 59) begin
        do_reset($urandom_range(0, 1) == 1, 8'($urandom));
      end else begin
        drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 8'($urandom));
      end
    end
    idle(2);

    chk("pending_reads", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
